// File: rtl/himm_axil_regfile_pkg.sv
// Shared definitions for the AXI4-Lite register file: response codes,
// write-channel FSM states and address-decode width helpers.
package himm_axil_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ADDR,
      W_DATA,
      W_RESP
   } wr_state_e;

   function automatic int unsigned idx_width(input int unsigned num_regs);
      return $clog2(num_regs);
   endfunction

   function automatic int unsigned off_width(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/himm_axil_regfile.sv
// AXI4-Lite slave register file with byte strobes, read-only slots and a
// per-register write strobe. Define HIMM_AXIL_SLVERR_EN for SLVERR responses.
module himm_axil_regfile
   import himm_axil_pkg::*;
#(
   parameter int unsigned                    NUM_REGS   = 16,
   parameter int unsigned                    DATA_WIDTH = 32,
   parameter int unsigned                    ADDR_WIDTH = 8,
   parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                             ACLK,
   input  logic                             ARESETN,
   input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
   input  logic [2:0]                       S_AXI_AWPROT,
   input  logic                             S_AXI_AWVALID,
   output logic                             S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]            S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
   input  logic                             S_AXI_WVALID,
   output logic                             S_AXI_WREADY,
   output logic [1:0]                       S_AXI_BRESP,
   output logic                             S_AXI_BVALID,
   input  logic                             S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
   input  logic [2:0]                       S_AXI_ARPROT,
   input  logic                             S_AXI_ARVALID,
   output logic                             S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
   output logic [1:0]                       S_AXI_RRESP,
   output logic                             S_AXI_RVALID,
   input  logic                             S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q,
   output logic [NUM_REGS-1:0]              wr_pulse,
   input  logic [NUM_REGS*DATA_WIDTH-1:0]   ro_d
);

   localparam int unsigned IDX_W  = idx_width(NUM_REGS);
   localparam int unsigned OFF_W  = off_width(DATA_WIDTH);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
`ifdef HIMM_AXIL_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   wr_state_e                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]          awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
   logic [STRB_W-1:0]              wstrb_q, wstrb_d;
   logic [1:0]                     bresp_q, bresp_d;
   logic [NUM_REGS-1:0]            wr_pulse_q, wr_pulse_d;
   logic [NUM_REGS*DATA_WIDTH-1:0] reg_d;
   logic                           rdy_q, rdy_d;
   logic                           rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
   logic [1:0]                     rresp_q, rresp_d;

   logic                  aw_hs, w_hs, ar_hs, commit;
   logic [ADDR_WIDTH-1:0] c_addr;
   logic [DATA_WIDTH-1:0] c_data;
   logic [STRB_W-1:0]     c_strb;
   logic [IDX_W-1:0]      c_idx, r_idx;
   logic                  c_oor, c_err, r_oor;
   logic                  unused_prot;

   assign unused_prot   = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // rdy_q keeps every READY low until the first edge after reset release
   assign S_AXI_AWREADY = rdy_q && (state_q == W_IDLE || state_q == W_DATA);
   assign S_AXI_WREADY  = rdy_q && (state_q == W_IDLE || state_q == W_ADDR);
   assign S_AXI_BVALID  = (state_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = rdy_q && !rvalid_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign wr_pulse      = wr_pulse_q;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
   assign rdy_d = 1'b1;

   // The edge that accepts the second half of a write is also the commit edge
   always_comb begin
      state_d  = state_q;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      bresp_d  = bresp_q;
      commit   = 1'b0;
      c_addr   = S_AXI_AWADDR;
      c_data   = S_AXI_WDATA;
      c_strb   = S_AXI_WSTRB;
      case (state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
            end else if (aw_hs) begin
               awaddr_d = S_AXI_AWADDR;
               state_d  = W_ADDR;
            end else if (w_hs) begin
               wdata_d = S_AXI_WDATA;
               wstrb_d = S_AXI_WSTRB;
               state_d = W_DATA;
            end
         end
         W_ADDR: begin
            if (w_hs) begin
               commit = 1'b1;
               c_addr = awaddr_q;
            end
         end
         W_DATA: begin
            if (aw_hs) begin
               commit = 1'b1;
               c_data = wdata_q;
               c_strb = wstrb_q;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) state_d = W_IDLE;
         end
         default: state_d = W_IDLE;
      endcase
      c_idx = c_addr[OFF_W +: IDX_W];
      c_oor = (c_addr >> (OFF_W + IDX_W)) != '0;
      c_err = c_oor || RO_MASK[c_idx];
      if (commit) begin
         state_d = W_RESP;
         bresp_d = (c_err && SLVERR_EN) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
   end

   always_comb begin
      reg_d      = reg_q;
      wr_pulse_d = '0;
      if (commit && !c_err) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (c_idx == IDX_W'(i)) begin
               for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (c_strb[b]) reg_d[i*DATA_WIDTH + b*8 +: 8] = c_data[b*8 +: 8];
               end
               wr_pulse_d[i] = |c_strb;
            end
         end
      end
   end

   always_comb begin
      r_idx    = S_AXI_ARADDR[OFF_W +: IDX_W];
      r_oor    = (S_AXI_ARADDR >> (OFF_W + IDX_W)) != '0;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         if (r_oor) begin
            rdata_d = '0;
         end else if (RO_MASK[r_idx]) begin
            rdata_d = ro_d[r_idx*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            rdata_d = reg_q[r_idx*DATA_WIDTH +: DATA_WIDTH];
         end
         rresp_d = (r_oor && SLVERR_EN) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= W_IDLE;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= '0;
         wr_pulse_q <= '0;
         reg_q      <= RESET_VAL;
         rdy_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         state_q    <= state_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         reg_q      <= reg_d;
         rdy_q      <= rdy_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

endmodule

// File: tb/tb_himm_axil_regfile.sv
// Self-checking bench for himm_axil_regfile: directed vector table, hand-written
// handshake corner cases and randomized traffic against a behavioural model.
module tb_himm_axil_regfile;

   localparam logic [511:0] RV = {384'h0, 32'h0000BEEF, 32'h0, 32'h5A5A0001, 32'h0};
   localparam logic [1:0] RSP_OK = 2'b00;
`ifdef HIMM_AXIL_SLVERR_EN
   localparam logic [1:0] RSP_ERR = 2'b10;
`else
   localparam logic [1:0] RSP_ERR = 2'b00;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   awaddr, araddr;
   logic [2:0]   awprot, arprot;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [511:0] reg_q, ro_d;
   logic [15:0]  wr_pulse;

   int checks = 0;
   int errors = 0;
   logic [31:0]  mdl [16];
   logic [511:0] rv_v;

   always #5 clk = ~clk;

   himm_axil_regfile #(
      .NUM_REGS(16), .DATA_WIDTH(32), .ADDR_WIDTH(8),
      .RO_MASK(16'h0020), .RESET_VAL(RV)
   ) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .reg_q(reg_q), .wr_pulse(wr_pulse), .ro_d(ro_d)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // ---- behavioural model: register index = byte address / 4, 16 slots, slot 5 read-only
   function automatic int unsigned idx_of(input logic [7:0] a);
      return int'(a) / 4;
   endfunction

   function automatic bit writable(input logic [7:0] a);
      return idx_of(a) < 16 && idx_of(a) != 5;
   endfunction

   function automatic logic [1:0] exp_wresp(input logic [7:0] a);
      return writable(a) ? RSP_OK : RSP_ERR;
   endfunction

   function automatic logic [1:0] exp_rresp(input logic [7:0] a);
      return (idx_of(a) < 16) ? RSP_OK : RSP_ERR;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [7:0] a);
      if (idx_of(a) >= 16) return 32'h0;
      if (idx_of(a) == 5) return ro_d[5*32 +: 32];
      return mdl[idx_of(a)];
   endfunction

   function automatic logic [15:0] exp_pulse(input logic [7:0] a, input logic [3:0] s);
      return (writable(a) && s != 4'h0) ? (16'h1 << idx_of(a)) : 16'h0;
   endfunction

   function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      if (writable(a))
         for (int b = 0; b < 4; b++)
            if (s[b]) mdl[idx_of(a)][8*b +: 8] = d[8*b +: 8];
   endfunction

   function automatic void model_reset();
      rv_v = RV;
      for (int i = 0; i < 16; i++) mdl[i] = rv_v[i*32 +: 32];
   endfunction

   function automatic logic [511:0] model_regq();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = mdl[i];
      return r;
   endfunction

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input string nm);
      int n;
      logic aw_hs, w_hs;
      logic [15:0] ep;
      ep = exp_pulse(a, s);
      @(negedge clk);
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 50) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clk);
         n++;
         if (aw_hs) awvalid = 1'b0;
         if (w_hs) wvalid = 1'b0;
      end
      chk({nm, "_accept"}, n < 50, 1);
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(a, d, s);
      chk({nm, "_bvalid"}, bvalid, 1);
      chk({nm, "_pulse"}, wr_pulse, ep);
      chk({nm, "_regq"}, reg_q, model_regq());
      chk({nm, "_bresp"}, bresp, er);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk({nm, "_pulse_clr"}, wr_pulse, 0);
      chk({nm, "_bvalid_clr"}, bvalid, 0);
   endtask

   task automatic do_read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input int hold, input string nm);
      int n;
      logic hs;
      logic [31:0] held;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      while (arvalid && n < 50) begin
         hs = arvalid && arready;
         @(negedge clk);
         n++;
         if (hs) arvalid = 1'b0;
      end
      chk({nm, "_accept"}, n < 50, 1);
      arvalid = 1'b0;
      chk({nm, "_rvalid"}, rvalid, 1);
      chk({nm, "_rdata"}, rdata, ed);
      chk({nm, "_rresp"}, rresp, er);
      held = rdata;
      for (int k = 0; k < hold; k++) begin
         ro_d[5*32 +: 32] = $urandom;
         @(negedge clk);
         chk({nm, "_hold_rdata"}, rdata, held);
         chk({nm, "_hold_arready"}, {rvalid, arready}, 2'b10);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk({nm, "_rvalid_clr"}, rvalid, 0);
   endtask

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      rst_n = 1'b0;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      for (int i = 0; i < 16; i++) ro_d[i*32 +: 32] = $urandom;
      ro_d[5*32 +: 32] = 32'hCAFEF00D;
      model_reset();

      tbl[0]  = '{1'b1, 8'h00, 32'h1,        4'hF, 32'h0,        RSP_OK};
      tbl[1]  = '{1'b1, 8'h04, 32'h2,        4'hF, 32'h0,        RSP_OK};
      tbl[2]  = '{1'b1, 8'h08, 32'h3,        4'hF, 32'h0,        RSP_OK};
      tbl[3]  = '{1'b1, 8'h0C, 32'h4,        4'hF, 32'h0,        RSP_OK};
      tbl[4]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h1,        RSP_OK};
      tbl[5]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h2,        RSP_OK};
      tbl[6]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h3,        RSP_OK};
      tbl[7]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h4,        RSP_OK};
      tbl[8]  = '{1'b1, 8'h08, 32'hAABBCCDD, 4'hF, 32'h0,        RSP_OK};
      tbl[9]  = '{1'b1, 8'h08, 32'h11223344, 4'h5, 32'h0,        RSP_OK};
      tbl[10] = '{1'b0, 8'h08, 32'h0,        4'h0, 32'hAA22CC44, RSP_OK};
      tbl[11] = '{1'b1, 8'h14, 32'h0,        4'hF, 32'h0,        RSP_ERR};
      tbl[12] = '{1'b0, 8'h14, 32'h0,        4'h0, 32'hCAFEF00D, RSP_OK};
      tbl[13] = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h0,        RSP_ERR};
      tbl[14] = '{1'b1, 8'h80, 32'hDEAD,     4'hF, 32'h0,        RSP_ERR};
      tbl[15] = '{1'b1, 8'h0C, 32'h55,       4'h0, 32'h0,        RSP_OK};
      tbl[16] = '{1'b0, 8'h0D, 32'h0,        4'h0, 32'h4,        RSP_OK};
      tbl[17] = '{1'b1, 8'h08, 32'h3,        4'hF, 32'h0,        RSP_OK};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_readies", {awready, wready, arready}, 3'b000);
      chk("rst_valids", {bvalid, rvalid}, 2'b00);
      chk("rst_resps", {bresp, rresp}, 4'h0);
      chk("rst_rdata", rdata, 0);
      chk("rst_pulse", wr_pulse, 0);
      chk("rst_regq", reg_q, RV);
      rst_n = 1'b1;
      #1 chk("rel_readies_low", {awready, wready, arready}, 3'b000);
      @(negedge clk);
      chk("rel_readies_high", {awready, wready, arready}, 3'b111);

      for (int i = 0; i < NV; i++) begin
         if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_resp, $sformatf("tbl%0d_wr", i));
         else           do_read(tbl[i].addr, tbl[i].exp_rdata, tbl[i].exp_resp, 0, $sformatf("tbl%0d_rd", i));
      end

      // W three cycles ahead of AW, then BREADY held off with a second write pending
      @(negedge clk);
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("wfirst_rdy", {awready, wready, bvalid}, 3'b100);
      repeat (2) @(negedge clk);
      chk("wfirst_wait", {awready, wready, bvalid}, 3'b100);
      awaddr = 8'h10; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      model_write(8'h10, 32'h77, 4'hF);
      chk("wfirst_bvalid", bvalid, 1);
      chk("wfirst_pulse", wr_pulse, 16'h0010);
      chk("wfirst_regq", reg_q, model_regq());
      awaddr = 8'h10; awvalid = 1'b1; wdata = 32'hBAD; wvalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bhold_bvalid", bvalid, 1);
         chk("bhold_bresp", bresp, RSP_OK);
         chk("bhold_rdy", {awready, wready}, 2'b00);
         chk("bhold_pulse", wr_pulse, 0);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      chk("bhold_done", bvalid, 0);
      chk("bhold_regq", reg_q, model_regq());
      @(negedge clk);
      chk("bhold_no_second", {bvalid, wr_pulse}, 17'h0);

      // read and write to the same register commit on the same edge
      @(negedge clk);
      awaddr = 8'h08; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 8'h08; arvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("rw_same_rvalid", rvalid, 1);
      chk("rw_same_rdata_old", rdata, 32'h3);
      chk("rw_same_bvalid", bvalid, 1);
      model_write(8'h08, 32'h9, 4'hF);
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      do_read(8'h08, 32'h9, RSP_OK, 0, "rw_same_after");

      // randomized traffic
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 5) == 0) a = 8'($urandom_range(64, 255));
         else                           a = 8'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom);
            do_write(a, d, s, exp_wresp(a), "rnd_wr");
         end else begin
            ro_d[5*32 +: 32] = $urandom;
            do_read(a, exp_rd(a), exp_rresp(a), int'($urandom_range(0, 2)), "rnd_rd");
         end
      end

      // reset while the address half of a write is held
      @(negedge clk);
      awaddr = 8'h04; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("mid_waddr_rdy", {awready, wready}, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
      chk("mid_rst_reg1", reg_q[63:32], 32'h5A5A0001);
      chk("mid_rst_regq", reg_q, model_regq());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_readies", {awready, wready, arready}, 3'b111);
      chk("mid_rel_bvalid", bvalid, 0);
      do_write(8'h04, 32'h12345678, 4'hF, RSP_OK, "post_rst_wr");
      do_read(8'h04, 32'h12345678, RSP_OK, 1, "post_rst_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
